// File: rtl/multi_dataflow_frame_feeder_pkg.sv
// Shared types for the multi_dataflow frame feeder: control/flag records and FSM encoding.
package multi_dataflow_package;

    localparam int unsigned LEN_WIDTH_DEF = 32;
    localparam int unsigned NFR_WIDTH_DEF = 16;

    typedef struct packed {
        logic                     start;
        logic [LEN_WIDTH_DEF-1:0] frame_len;
        logic [NFR_WIDTH_DEF-1:0] num_frames;
    } ctrl_frame_feeder_t;

    typedef struct packed {
        logic                     busy;
        logic                     done;
        logic [NFR_WIDTH_DEF-1:0] frame_cnt;
        logic [LEN_WIDTH_DEF-1:0] pel_cnt;
    } flags_frame_feeder_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SIZE = 2'd1,
        PEL  = 2'd2,
        DONE = 2'd3
    } frame_feeder_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal valid/ready stream interface with data and byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/multi_dataflow_frame_feeder.sv
// Splits one raw pixel stream into a size-token stream and a framed pixel stream
// for the multi_dataflow kernel, num_frames frames of frame_len pixels per job.
module multi_dataflow_frame_feeder
    import multi_dataflow_package::*;
#(
    parameter int unsigned PEL_WIDTH  = 32,
    parameter int unsigned SIZE_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int unsigned NFR_WIDTH  = NFR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    hwpe_stream_intf_stream.sink   pel_i,
    hwpe_stream_intf_stream.source pel_o,
    hwpe_stream_intf_stream.source size_o,
    input  ctrl_frame_feeder_t    ctrl_i,
    output flags_frame_feeder_t   flags_o
);

    frame_feeder_state_t  state_r;
    logic [LEN_WIDTH-1:0] frame_len_r;
    logic [NFR_WIDTH-1:0] num_frames_r;
    logic [LEN_WIDTH-1:0] pel_cnt_r;
    logic [NFR_WIDTH-1:0] frame_cnt_r;

    logic in_pel_s;
    logic in_size_s;
    logic pel_hs_s;
    logic last_pel_s;
    logic last_frame_s;

    assign in_pel_s     = (state_r == PEL);
    assign in_size_s    = (state_r == SIZE);
    assign pel_hs_s     = in_pel_s & pel_i.valid & pel_o.ready;
    // Latched values are non-zero whenever PEL is reachable, so the minus-one never wraps.
    assign last_pel_s   = (pel_cnt_r == (frame_len_r - LEN_WIDTH'(1)));
    assign last_frame_s = (frame_cnt_r == (num_frames_r - NFR_WIDTH'(1)));

    // Pixel path is a pure combinational gate around the PEL state.
    assign pel_o.valid  = in_pel_s ? pel_i.valid : 1'b0;
    assign pel_o.data   = PEL_WIDTH'(pel_i.data);
    assign pel_o.strb   = pel_i.strb;
    assign pel_i.ready  = in_pel_s ? pel_o.ready : 1'b0;

    assign size_o.valid = in_size_s;
    assign size_o.data  = in_size_s ? SIZE_WIDTH'(frame_len_r) : '0;
    assign size_o.strb  = '1;

    assign flags_o.busy      = in_size_s | in_pel_s;
    assign flags_o.done      = (state_r == DONE);
    assign flags_o.frame_cnt = frame_cnt_r;
    assign flags_o.pel_cnt   = pel_cnt_r;

    // Job sequencer: latch parameters, emit size token, count pixels and frames.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            frame_len_r  <= '0;
            num_frames_r <= '0;
            pel_cnt_r    <= '0;
            frame_cnt_r  <= '0;
        end else if (clear_i) begin
            state_r      <= IDLE;
            pel_cnt_r    <= '0;
            frame_cnt_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ctrl_i.start) begin
                        frame_len_r  <= ctrl_i.frame_len;
                        num_frames_r <= ctrl_i.num_frames;
                        pel_cnt_r    <= '0;
                        frame_cnt_r  <= '0;
                        if ((ctrl_i.frame_len == '0) || (ctrl_i.num_frames == '0)) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= SIZE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SIZE: begin
                    if (size_o.ready) begin
                        state_r <= PEL;
                    end else begin
                        state_r <= SIZE;
                    end
                end
                PEL: begin
                    if (pel_hs_s) begin
                        if (last_pel_s) begin
                            pel_cnt_r <= '0;
                            if (last_frame_s) begin
                                state_r <= DONE;
                            end else begin
                                frame_cnt_r <= frame_cnt_r + NFR_WIDTH'(1);
                                state_r     <= SIZE;
                            end
                        end else begin
                            pel_cnt_r <= pel_cnt_r + LEN_WIDTH'(1);
                        end
                    end else begin
                        state_r <= PEL;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_dataflow_frame_feeder.sv
// Self-checking bench: table of jobs plus hand-written clear/reset/restart sequences, token scoreboard.
module tb_multi_dataflow_frame_feeder;
    import multi_dataflow_package::*;

    typedef struct {
        bit          is_size;
        logic [31:0] data;
        logic [3:0]  strb;
    } tok_t;

    typedef struct {
        logic [31:0] len;
        logic [15:0] nfr;
        int          pmode;
        int          smode;
        bit          restart;
        logic [15:0] exp_fcnt;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clear;
    ctrl_frame_feeder_t  ctrl;
    flags_frame_feeder_t flags;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pel_in ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pel_out ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) size_out ();

    multi_dataflow_frame_feeder dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clear_i(clear),
        .pel_i  (pel_in),
        .pel_o  (pel_out),
        .size_o (size_out),
        .ctrl_i (ctrl),
        .flags_o(flags)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    tok_t        exp_q[$];
    logic [31:0] src_q[$];
    int          pmode = 0;
    int          smode = 0;
    int          sz_wait = 0;
    int          done_cnt = 0;
    bit          pel_hs_r = 1'b0;
    bit          last_hs = 1'b0;
    bit          chk_done_lat = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        tok_t e;
        chk("size_excl", {63'd0, size_out.valid & pel_in.ready}, 64'd0);
        if (flags.done) begin
            done_cnt++;
            chk("done_busy", {63'd0, flags.busy}, 64'd0);
            if (chk_done_lat) chk("done_lat", {63'd0, last_hs}, 64'd1);
        end
        if (size_out.valid && size_out.ready) begin
            if (exp_q.size() == 0) begin
                chk("size_extra", {63'd0, size_out.valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("size_tok", {27'd0, 1'b1, size_out.data, size_out.strb}, {27'd0, e.is_size, e.data, e.strb});
            end
        end
        if (pel_out.valid && pel_out.ready) begin
            if (exp_q.size() == 0) begin
                chk("pel_extra", {63'd0, pel_out.valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pel_tok", {27'd0, 1'b0, pel_out.data, pel_out.strb}, {27'd0, e.is_size, e.data, e.strb});
            end
        end
        last_hs  = pel_out.valid & pel_out.ready;
        pel_hs_r = pel_in.valid & pel_in.ready;
    end

    // Upstream pixel source and downstream ready generators, driven just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (pel_hs_r && src_q.size() > 0) void'(src_q.pop_front());
        if (!(pel_in.valid && !pel_hs_r && src_q.size() > 0)) begin
            pel_in.valid = (src_q.size() > 0) && ((pmode != 2) || ($urandom_range(0, 3) != 0));
        end
        pel_in.data = pel_in.valid ? src_q[0] : 32'h0;
        pel_in.strb = pel_in.data[3:0];
        case (pmode)
            0:       pel_out.ready = 1'b1;
            1:       pel_out.ready = ~pel_out.ready;
            default: pel_out.ready = 1'($urandom_range(0, 1));
        endcase
        if (smode == 0) begin
            size_out.ready = 1'b1;
        end else begin
            if (size_out.valid) sz_wait++;
            else sz_wait = 0;
            size_out.ready = (sz_wait >= 3);
        end
    end

    task automatic do_start(input logic [31:0] len, input logic [15:0] nfr);
        @(posedge clk); #1;
        ctrl.start      = 1'b1;
        ctrl.frame_len  = len;
        ctrl.num_frames = nfr;
        @(posedge clk); #1;
        ctrl.start      = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] f, input logic [31:0] p);
        bit ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            ok = (flags.frame_cnt == f) && (flags.pel_cnt == p);
        end
        chk("cnt_reach", {63'd0, ok}, 64'd1);
    endtask

    task automatic push_frames(input logic [31:0] len, input logic [15:0] nfr, input int idx);
        logic [31:0] px;
        for (int f = 0; f < int'(nfr); f++) begin
            exp_q.push_back('{1'b1, len, 4'hF});
            for (int i = 0; i < int'(len); i++) begin
                px = 32'hA0 + 32'(idx * 256 + f * 16 + i);
                exp_q.push_back('{1'b0, px, px[3:0]});
                src_q.push_back(px);
            end
        end
    endtask

    task automatic run_job(input vec_t v, input int idx);
        bit nz;
        bit seen;
        int d0;
        pmode = v.pmode;
        smode = v.smode;
        nz = (v.len != 32'd0) && (v.nfr != 16'd0);
        if (nz) push_frames(v.len, v.nfr, idx);
        chk_done_lat = nz;
        d0 = done_cnt;
        do_start(v.len, v.nfr);
        @(negedge clk);
        if (nz) begin
            chk("start_lat", {63'd0, size_out.valid}, 64'd1);
        end else begin
            chk("zero_done", {63'd0, flags.done}, 64'd1);
            chk("zero_novalid", {62'd0, size_out.valid, pel_out.valid}, 64'd0);
        end
        if (v.restart) begin
            wait_cnt(16'd1, 32'd2);
            do_start(32'd2, 16'd1);
        end
        seen = flags.done;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            seen = flags.done;
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        chk("fcnt_done", {48'd0, flags.frame_cnt}, {48'd0, v.exp_fcnt});
        chk("pcnt_done", {32'd0, flags.pel_cnt}, 64'd0);
        @(negedge clk);
        chk("done_1cyc", {63'd0, flags.done}, 64'd0);
        chk("done_once", 64'(done_cnt), 64'(d0 + 1));
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("idle_quiet", {61'd0, size_out.valid, pel_out.valid, flags.busy}, 64'd0);
        chk("fcnt_hold", {48'd0, flags.frame_cnt}, {48'd0, v.exp_fcnt});
        chk_done_lat = 1'b0;
    endtask

    vec_t vecs[8];
    vec_t tail;
    int   d0;

    initial begin
        vecs[0] = '{32'd4, 16'd1, 0, 0, 1'b0, 16'd0};
        vecs[1] = '{32'd3, 16'd3, 1, 1, 1'b0, 16'd2};
        vecs[2] = '{32'd0, 16'd5, 0, 0, 1'b0, 16'd0};
        vecs[3] = '{32'd5, 16'd0, 0, 0, 1'b0, 16'd0};
        vecs[4] = '{32'd2, 16'd4, 2, 0, 1'b0, 16'd3};
        vecs[5] = '{32'd1, 16'd2, 2, 1, 1'b0, 16'd1};
        vecs[6] = '{32'd8, 16'd3, 1, 0, 1'b1, 16'd2};
        vecs[7] = '{32'd2, 16'd1, 0, 0, 1'b0, 16'd0};

        rst_n          = 1'b0;
        clear          = 1'b0;
        ctrl           = '0;
        pel_in.valid   = 1'b0;
        pel_in.data    = 32'h0;
        pel_in.strb    = 4'h0;
        pel_out.ready  = 1'b0;
        size_out.ready = 1'b0;
        #12;
        chk("rst_outs", {59'd0, size_out.valid, pel_out.valid, pel_in.ready, flags.busy, flags.done}, 64'd0);
        chk("rst_cnt", {16'd0, flags.frame_cnt, flags.pel_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_job(vecs[i], i);

        // Clear after two of five pixels, then a normal short job.
        pmode = 0;
        smode = 0;
        exp_q.push_back('{1'b1, 32'd5, 4'hF});
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{1'b0, 32'hB0 + 32'(i), 4'(i)});
            src_q.push_back(32'hB0 + 32'(i));
        end
        d0 = done_cnt;
        do_start(32'd5, 16'd1);
        wait_cnt(16'd0, 32'd2);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_idle", {59'd0, size_out.valid, pel_out.valid, pel_in.ready, flags.busy, flags.done}, 64'd0);
        chk("clr_cnt", {16'd0, flags.frame_cnt, flags.pel_cnt}, 64'd0);
        repeat (4) @(negedge clk);
        chk("clr_nodone", 64'(done_cnt), 64'(d0));
        chk("clr_sb", 64'(exp_q.size()), 64'd0);
        tail = '{32'd2, 16'd1, 0, 0, 1'b0, 16'd0};
        run_job(tail, 8);

        // Maximum frame length: size token carries all ones and the counter advances normally.
        exp_q.push_back('{1'b1, 32'hFFFF_FFFF, 4'hF});
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{1'b0, 32'hC0 + 32'(i), 4'(i)});
            src_q.push_back(32'hC0 + 32'(i));
        end
        do_start(32'hFFFF_FFFF, 16'd1);
        repeat (8) @(negedge clk);
        chk("max_pcnt", {32'd0, flags.pel_cnt}, 64'd3);
        chk("max_state", {62'd0, flags.busy, flags.done}, 64'd2);
        chk("max_sb", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("max_clr", {63'd0, flags.busy}, 64'd0);

        // Asynchronous reset in the middle of a frame, between clock edges.
        push_frames(32'd6, 16'd1, 9);
        do_start(32'd6, 16'd1);
        wait_cnt(16'd0, 32'd3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", {59'd0, size_out.valid, pel_out.valid, pel_in.ready, flags.busy, flags.done}, 64'd0);
        chk("arst_cnt", {16'd0, flags.frame_cnt, flags.pel_cnt}, 64'd0);
        exp_q.delete();
        src_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tail = '{32'd4, 16'd1, 0, 0, 1'b0, 16'd0};
        run_job(tail, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
